// File: rtl/lsu_ctrl.sv
// ---------------------------------------------------------------------------
// lsu_ctrl
//
// Load/store unit sitting between the execute stage and a word-addressed data
// memory. Byte addresses from the pipeline become word indices for the
// memory. Byte and halfword loads are extracted from the returned word and
// sign- or zero-extended. Byte and halfword stores are done as
// read-modify-write, because the memory only writes whole words. Every request
// ends with a single-cycle response pulse. All outputs come straight from
// flops.
//
// Build option:
//   LSU_MISALIGN_TRAP_EN  defined   -> misaligned half/word requests are
//                                      rejected with rsp_err_o and never
//                                      touch memory.
//                         undefined -> misaligned half/word addresses are
//                                      aligned down and the access is
//                                      performed normally.
//   Size 2'b11 is rejected in both builds.
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   req_valid_i/ready_o request handshake (ready only while idle)
//   req_we_i            1 = store, 0 = load
//   req_size_i          00 byte, 01 half, 10 word, 11 reserved
//   req_unsigned_i      zero-extend sub-word loads
//   req_addr_i          byte address
//   req_wdata_i         store data, taken from the low bits
//   rsp_valid_o         one-cycle response pulse
//   rsp_rdata_o         formatted load data (0 for stores and errors)
//   rsp_err_o           request rejected, qualified by rsp_valid_o
//   mem_addr_o          word index, zero-extended to XLEN
//   mem_load_o          one-cycle read strobe
//   mem_store_o         one-cycle write strobe
//   mem_wdata_o         full word to write
//   mem_rdata_i         read word
//   mem_rvalid_i        mem_rdata_i valid (only looked at while waiting)
// ---------------------------------------------------------------------------
module lsu_ctrl #(
    parameter int MEM_WORDS = 256,
    parameter int XLEN      = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            req_valid_i,
    output logic            req_ready_o,
    input  logic            req_we_i,
    input  logic [1:0]      req_size_i,
    input  logic            req_unsigned_i,
    input  logic [XLEN-1:0] req_addr_i,
    input  logic [XLEN-1:0] req_wdata_i,
    output logic            rsp_valid_o,
    output logic [XLEN-1:0] rsp_rdata_o,
    output logic            rsp_err_o,
    output logic [XLEN-1:0] mem_addr_o,
    output logic            mem_load_o,
    output logic            mem_store_o,
    output logic [XLEN-1:0] mem_wdata_o,
    input  logic [XLEN-1:0] mem_rdata_i,
    input  logic            mem_rvalid_i
);

    localparam int IDX_W = $clog2(MEM_WORDS);

    typedef enum logic [2:0] {
        IDLE,
        RD,
        WAIT,
        WR,
        RESP
    } lsuState_t;

    lsuState_t       state_q;
    lsuState_t       state_d;

    logic            reqReady_q;
    logic            rspValid_q;
    logic [XLEN-1:0] rspRdata_q;
    logic            rspErr_q;
    logic [XLEN-1:0] memAddr_q;
    logic            memLoad_q;
    logic            memStore_q;
    logic [XLEN-1:0] memWdata_q;

    logic [1:0]      off_q;
    logic [1:0]      size_q;
    logic            unsigned_q;
    logic            we_q;
    logic [15:0]     wdata_q;

    logic            accept;
    logic [1:0]      reqOff;
    logic            reqMisaligned;
    logic            reqErr;
    logic [1:0]      alignedOff;

    logic [4:0]      byteSel;
    logic [4:0]      halfSel;
    logic [7:0]      rdByte;
    logic [15:0]     rdHalf;
    logic [XLEN-1:0] loadData;
    logic [XLEN-1:0] mergeData;

    logic            unusedAddrBits;

    assign accept         = req_valid_i & reqReady_q;
    assign reqOff         = req_addr_i[1:0];
    assign unusedAddrBits = ^req_addr_i[XLEN-1:IDX_W+2];

    // Classify the incoming request. Only the reserved size is an error unless
    // the trap build is selected, in which case a misaligned half or word is
    // also rejected. Otherwise the offset is aligned down so the access lands
    // on the naturally aligned half or word containing the address.
    always_comb begin
        reqMisaligned = 1'b0;
        case (req_size_i)
            2'b01:   reqMisaligned = reqOff[0];
            2'b10:   reqMisaligned = (reqOff != 2'b00);
            default: reqMisaligned = 1'b0;
        endcase
`ifdef LSU_MISALIGN_TRAP_EN
        reqErr     = (req_size_i == 2'b11) | reqMisaligned;
        alignedOff = reqOff;
`else
        reqErr     = (req_size_i == 2'b11);
        alignedOff = reqOff;
        if (reqMisaligned) begin
            alignedOff = (req_size_i == 2'b01) ? {reqOff[1], 1'b0} : 2'b00;
        end
`endif
    end

    // Next-state logic. Errors go straight to the response, word stores skip
    // the read, and everything else reads the word first. The WAIT state holds
    // until the memory answers; any mem_rvalid_i seen in other states is
    // ignored because only WAIT looks at it.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (reqErr) begin
                        state_d = RESP;
                    end else if (req_we_i && (req_size_i == 2'b10)) begin
                        state_d = WR;
                    end else begin
                        state_d = RD;
                    end
                end
            end
            RD:      state_d = WAIT;
            WAIT: begin
                if (mem_rvalid_i) begin
                    state_d = we_q ? WR : RESP;
                end
            end
            WR:      state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State register. A synchronous reset drops any request in flight, so an
    // aborted operation never produces a response.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Load formatting and store merging both work on the word currently on
    // mem_rdata_i, using the latched (already aligned) offset. The byte lane
    // starts at bit 8*off; the half lane starts at bit 16*off[1].
    always_comb begin
        byteSel   = {off_q, 3'b000};
        halfSel   = {off_q[1], 4'b0000};
        rdByte    = mem_rdata_i[byteSel +: 8];
        rdHalf    = mem_rdata_i[halfSel +: 16];
        loadData  = mem_rdata_i;
        mergeData = mem_rdata_i;
        case (size_q)
            2'b00: begin
                loadData = unsigned_q ? {{(XLEN-8){1'b0}}, rdByte}
                                      : {{(XLEN-8){rdByte[7]}}, rdByte};
                mergeData[byteSel +: 8] = wdata_q[7:0];
            end
            2'b01: begin
                loadData = unsigned_q ? {{(XLEN-16){1'b0}}, rdHalf}
                                      : {{(XLEN-16){rdHalf[15]}}, rdHalf};
                mergeData[halfSel +: 16] = wdata_q[15:0];
            end
            default: begin
            end
        endcase
    end

    // Output and request registers. Strobes and the handshake outputs are
    // decoded from the next state so each lines up with the cycle spent in
    // that state. Request fields and the word index are captured on
    // acceptance and held until the next acceptance. The read word is
    // consumed directly on the cycle mem_rvalid_i is seen in WAIT, either
    // into the response data (load) or into the merged write word (store).
    always_ff @(posedge clk) begin
        if (reset) begin
            reqReady_q <= 1'b1;
            rspValid_q <= 1'b0;
            rspRdata_q <= '0;
            rspErr_q   <= 1'b0;
            memAddr_q  <= '0;
            memLoad_q  <= 1'b0;
            memStore_q <= 1'b0;
            memWdata_q <= '0;
            off_q      <= 2'b00;
            size_q     <= 2'b00;
            unsigned_q <= 1'b0;
            we_q       <= 1'b0;
            wdata_q    <= '0;
        end else begin
            reqReady_q <= (state_d == IDLE);
            rspValid_q <= (state_d == RESP);
            memLoad_q  <= (state_d == RD);
            memStore_q <= (state_d == WR);
            rspErr_q   <= accept & reqErr;
            rspRdata_q <= '0;
            if (accept) begin
                off_q      <= alignedOff;
                size_q     <= req_size_i;
                unsigned_q <= req_unsigned_i;
                we_q       <= req_we_i;
                wdata_q    <= req_wdata_i[15:0];
                memAddr_q  <= {{(XLEN-IDX_W){1'b0}}, req_addr_i[IDX_W+1:2]};
                if (req_we_i && (req_size_i == 2'b10)) begin
                    memWdata_q <= req_wdata_i;
                end
            end
            if ((state_q == WAIT) && mem_rvalid_i) begin
                if (we_q) begin
                    memWdata_q <= mergeData;
                end else begin
                    rspRdata_q <= loadData;
                end
            end
        end
    end

    assign req_ready_o = reqReady_q;
    assign rsp_valid_o = rspValid_q;
    assign rsp_rdata_o = rspRdata_q;
    assign rsp_err_o   = rspErr_q;
    assign mem_addr_o  = memAddr_q;
    assign mem_load_o  = memLoad_q;
    assign mem_store_o = memStore_q;
    assign mem_wdata_o = memWdata_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// ---------------------------------------------------------------------------
// tb_lsu_ctrl
//
// Testbench for lsu_ctrl. A small memory responds to read strobes (with a
// selectable number of late cycles) and applies write strobes. Each request
// is run through a byte-level reference model that predicts the response,
// the latency, the strobe counts and the resulting memory word; the
// prediction is queued and a separate monitor compares it when the response
// pulse appears. Honours LSU_MISALIGN_TRAP_EN the same way the design does.
// ---------------------------------------------------------------------------
module tb_lsu_ctrl;

    localparam int MEM_WORDS = 256;
    localparam int XLEN      = 32;
    localparam int IDX_W     = $clog2(MEM_WORDS);

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
        int          loads;
        int          stores;
        logic [31:0] idx;
        logic        isStore;
    } ExpRsp;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            req_valid_i = 1'b0;
    logic            req_ready_o;
    logic            req_we_i = 1'b0;
    logic [1:0]      req_size_i = 2'b00;
    logic            req_unsigned_i = 1'b0;
    logic [XLEN-1:0] req_addr_i = '0;
    logic [XLEN-1:0] req_wdata_i = '0;
    logic            rsp_valid_o;
    logic [XLEN-1:0] rsp_rdata_o;
    logic            rsp_err_o;
    logic [XLEN-1:0] mem_addr_o;
    logic            mem_load_o;
    logic            mem_store_o;
    logic [XLEN-1:0] mem_wdata_o;
    logic [XLEN-1:0] mem_rdata_i;
    logic            mem_rvalid_i;

    logic [31:0] dutMem [MEM_WORDS];
    logic [31:0] refMem [MEM_WORDS];
    ExpRsp       expQ[$];
    int          rvalidDelay = 0;
    int          checkCount = 0;
    int          failCount = 0;
    int          edgeCount = 0;
    int          acceptEdge = 0;
    int          loadsSeen = 0;
    int          storesSeen = 0;

    lsu_ctrl #(
        .MEM_WORDS(MEM_WORDS),
        .XLEN     (XLEN)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .req_valid_i   (req_valid_i),
        .req_ready_o   (req_ready_o),
        .req_we_i      (req_we_i),
        .req_size_i    (req_size_i),
        .req_unsigned_i(req_unsigned_i),
        .req_addr_i    (req_addr_i),
        .req_wdata_i   (req_wdata_i),
        .rsp_valid_o   (rsp_valid_o),
        .rsp_rdata_o   (rsp_rdata_o),
        .rsp_err_o     (rsp_err_o),
        .mem_addr_o    (mem_addr_o),
        .mem_load_o    (mem_load_o),
        .mem_store_o   (mem_store_o),
        .mem_wdata_o   (mem_wdata_o),
        .mem_rdata_i   (mem_rdata_i),
        .mem_rvalid_i  (mem_rvalid_i)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    // Edge counter used to measure response latency.
    always @(posedge clk) edgeCount <= edgeCount + 1;

    function automatic logic [31:0] initWord(input int i);
        if (i == 4) return 32'h80A1B2C3;
        return (32'(i) * 32'h9E3779B1) ^ 32'h5A5A0F0F;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checkCount++;
        if (act !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Reference model: works on bytes and masks of the memory image, applies
    // the store to the image and returns the expected response.
    task automatic modelRequest(input logic we, input logic [1:0] size, input logic uns,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                input int delay, output ExpRsp e);
        int          off;
        int          nBytes;
        logic [31:0] mask;
        logic [31:0] word;
        logic [31:0] val;
        logic        misaligned;
        off       = int'(addr % 4);
        e.idx     = (addr / 4) % MEM_WORDS;
        e.rdata   = '0;
        e.err     = 1'b0;
        e.lat     = 0;
        e.loads   = 0;
        e.stores  = 0;
        e.isStore = 1'b0;
        nBytes = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
        misaligned = (size != 2'd3) && ((off % nBytes) != 0);
        if (size == 2'd3) e.err = 1'b1;
`ifdef LSU_MISALIGN_TRAP_EN
        if (misaligned) e.err = 1'b1;
`else
        if (misaligned) off = off - (off % nBytes);
`endif
        if (e.err) begin
            e.lat = 1;
            return;
        end
        mask = (nBytes == 4) ? 32'hFFFFFFFF : ((32'd1 << (8 * nBytes)) - 32'd1);
        word = refMem[e.idx];
        if (!we) begin
            val = (word >> (8 * off)) & mask;
            if (!uns && nBytes < 4 && val[8*nBytes-1]) val = val | ~mask;
            e.rdata = val;
            e.lat   = 3 + delay;
            e.loads = 1;
        end else begin
            e.isStore = 1'b1;
            e.stores  = 1;
            if (nBytes == 4) begin
                refMem[e.idx] = wdata;
                e.lat = 2;
            end else begin
                refMem[e.idx] = (word & ~(mask << (8 * off))) | ((wdata & mask) << (8 * off));
                e.lat   = 4 + delay;
                e.loads = 1;
            end
        end
    endtask

    // Memory image seen by the design; applies write strobes.
    initial begin
        for (int i = 0; i < MEM_WORDS; i++) dutMem[i] = initWord(i);
        forever begin
            @(negedge clk);
            if (!reset && mem_store_o) dutMem[mem_addr_o[IDX_W-1:0]] = mem_wdata_o;
        end
    end

    // Read responder: data appears after the edge that samples the read
    // strobe, plus rvalidDelay extra cycles.
    initial begin
        logic [31:0] rdIdx;
        int          d;
        mem_rvalid_i = 1'b0;
        mem_rdata_i  = '0;
        forever begin
            @(negedge clk);
            if (!reset && mem_load_o) begin
                rdIdx = mem_addr_o;
                d     = rvalidDelay;
                @(posedge clk);
                repeat (d) @(posedge clk);
                #1;
                mem_rdata_i  = dutMem[rdIdx[IDX_W-1:0]];
                mem_rvalid_i = 1'b1;
                @(posedge clk);
                #1;
                mem_rvalid_i = 1'b0;
                mem_rdata_i  = $urandom;
            end
        end
    end

    // Monitor: tracks acceptance and strobe pulses, and compares every
    // response pulse against the oldest queued prediction.
    always @(negedge clk) begin
        ExpRsp e;
        if (reset) begin
            loadsSeen  = 0;
            storesSeen = 0;
        end else begin
            if (mem_load_o) loadsSeen++;
            if (mem_store_o) storesSeen++;
            if (rsp_valid_o) begin
                if (expQ.size() == 0) begin
                    checkOutput("unexpectedRsp", 32'(rsp_valid_o), 32'd0);
                end else begin
                    e = expQ.pop_front();
                    checkOutput("rspData", rsp_rdata_o, e.rdata);
                    checkOutput("rspErr", 32'(rsp_err_o), 32'(e.err));
                    checkOutput("rspLatency", edgeCount - acceptEdge + 1, e.lat);
                    checkOutput("loadPulses", loadsSeen, e.loads);
                    checkOutput("storePulses", storesSeen, e.stores);
                    if (!e.err) checkOutput("memAddr", mem_addr_o, e.idx);
                    if (e.isStore) checkOutput("memContent", dutMem[e.idx[IDX_W-1:0]], refMem[e.idx[IDX_W-1:0]]);
                end
            end
            if (req_valid_i && req_ready_o) begin
                acceptEdge = edgeCount + 1;
                loadsSeen  = 0;
                storesSeen = 0;
            end
        end
    end

    // Issues one request, queues its prediction and waits (bounded) for the
    // monitor to consume it.
    task automatic applyStimulus(input logic we, input logic [1:0] size, input logic uns,
                                 input logic [31:0] addr, input logic [31:0] wdata, input int delay);
        ExpRsp e;
        int    n;
        n = 0;
        while (req_ready_o !== 1'b1 && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (req_ready_o !== 1'b1) begin
            checkOutput("readyTimeout", 32'(req_ready_o), 32'd1);
            return;
        end
        rvalidDelay = delay;
        modelRequest(we, size, uns, addr, wdata, delay, e);
        expQ.push_back(e);
        req_we_i       = we;
        req_size_i     = size;
        req_unsigned_i = uns;
        req_addr_i     = addr;
        req_wdata_i    = wdata;
        req_valid_i    = 1'b1;
        @(posedge clk);
        #1;
        req_valid_i = 1'b0;
        req_addr_i  = $urandom;
        req_wdata_i = $urandom;
        n = 0;
        while (expQ.size() != 0 && n < 60) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (expQ.size() != 0) begin
            checkOutput("rspTimeout", expQ.size(), 32'd0);
            expQ.delete();
        end
    endtask

    // Main sequence: reset values, directed cases, reset abort, random mix.
    initial begin
        logic [1:0]  sz;
        logic [31:0] addr;
        int          r;
        for (int i = 0; i < MEM_WORDS; i++) refMem[i] = initWord(i);

        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("resetReady", 32'(req_ready_o), 32'd1);
        checkOutput("resetRspValid", 32'(rsp_valid_o), 32'd0);
        checkOutput("resetRspErr", 32'(rsp_err_o), 32'd0);
        checkOutput("resetRdata", rsp_rdata_o, 32'd0);
        checkOutput("resetMemLoad", 32'(mem_load_o), 32'd0);
        checkOutput("resetMemStore", 32'(mem_store_o), 32'd0);
        checkOutput("resetMemAddr", mem_addr_o, 32'd0);
        checkOutput("resetMemWdata", mem_wdata_o, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        $display("[TB] directed loads");
        applyStimulus(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 0);
        applyStimulus(1'b0, 2'b00, 1'b0, 32'h13, 32'h0, 0);
        applyStimulus(1'b0, 2'b00, 1'b1, 32'h13, 32'h0, 0);
        applyStimulus(1'b0, 2'b01, 1'b0, 32'h12, 32'h0, 0);
        applyStimulus(1'b0, 2'b01, 1'b1, 32'h10, 32'h0, 0);
        applyStimulus(1'b0, 2'b01, 1'b0, 32'h11, 32'h0, 0);
        applyStimulus(1'b0, 2'b10, 1'b1, 32'h12, 32'h0, 1);
        applyStimulus(1'b0, 2'b11, 1'b0, 32'h10, 32'h0, 0);
        applyStimulus(1'b1, 2'b11, 1'b0, 32'h10, 32'hDEAD, 0);
        applyStimulus(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 2);

        $display("[TB] directed stores");
        applyStimulus(1'b1, 2'b00, 1'b0, 32'h11, 32'hFFFFFF5A, 0);
        applyStimulus(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 0);
        applyStimulus(1'b1, 2'b10, 1'b0, 32'h10, 32'h12345678, 0);
        applyStimulus(1'b1, 2'b01, 1'b0, 32'h1B, 32'hCAFEBEEF, 1);
        applyStimulus(1'b0, 2'b10, 1'b0, 32'h410, 32'h0, 0);
        applyStimulus(1'b0, 2'b10, 1'b0, 32'h18, 32'h0, 0);

        $display("[TB] reset while waiting for read data");
        rvalidDelay    = 3;
        req_we_i       = 1'b1;
        req_size_i     = 2'b00;
        req_unsigned_i = 1'b0;
        req_addr_i     = 32'h21;
        req_wdata_i    = 32'hA5;
        req_valid_i    = 1'b1;
        @(posedge clk);
        #1;
        req_valid_i = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        checkOutput("abortReady", 32'(req_ready_o), 32'd1);
        checkOutput("abortMemLoad", 32'(mem_load_o), 32'd0);
        checkOutput("abortMemStore", 32'(mem_store_o), 32'd0);
        checkOutput("abortRspValid", 32'(rsp_valid_o), 32'd0);
        repeat (6) @(posedge clk);
        #1;
        applyStimulus(1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 0);
        applyStimulus(1'b0, 2'b00, 1'b1, 32'h21, 32'h0, 0);

        $display("[TB] random requests");
        for (int n = 0; n < 200; n++) begin
            r  = $urandom_range(0, 7);
            sz = (r == 7) ? 2'b11 : 2'(r % 3);
            addr = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 63));
            applyStimulus(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)),
                          addr, $urandom, $urandom_range(0, 2));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule

// File: doc/lsu_ctrl.md
Name: lsu_ctrl

Overview:
- Load/store unit between the execute stage and the word-addressed data memory.
- Accepts byte, halfword and word requests with byte addresses, and converts them to word-index accesses.
- Sign- or zero-extends load data.
- Performs read-modify-write for sub-word stores, since the memory only writes whole words.
- Returns a single-cycle response pulse to the pipeline.

Parameters:
- MEM_WORDS, 256, number of 32-bit words in data memory; must be a power of 2. IDX_W = log2(MEM_WORDS).
- XLEN, 32, data and address width.

Ports:
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- req_valid  in  1  request present
- req_ready  out  1  LSU can accept a request
- req_we  in  1  1 = store, 0 = load
- req_size  in  2  00 byte, 01 half, 10 word, 11 reserved
- req_unsigned  in  1  zero-extend load (LBU/LHU)
- req_addr  in  XLEN  byte address
- req_wdata  in  XLEN  store data; the value is taken from the low bits
- rsp_valid  out  1  one-cycle response pulse
- rsp_rdata  out  XLEN  formatted load data; 0 for stores and errors
- rsp_err  out  1  request rejected (misaligned or reserved size); qualified by rsp_valid
- mem_addr  out  XLEN  word index = req_addr[IDX_W+1:2], zero-extended
- mem_load  out  1  one-cycle read strobe
- mem_store  out  1  one-cycle write strobe
- mem_wdata  out  XLEN  full word to write
- mem_rdata  in  XLEN  read word
- mem_rvalid  in  1  mem_rdata valid; arrives one edge after the edge that samples mem_load

Behaviour:
- All outputs are registered.
- Reset values:
  - req_ready = 1.
  - All other outputs = 0.
  - state = IDLE.
- Handshake:
  - A request is accepted at an edge where req_valid & req_ready.
  - req_ready = 1 only in IDLE; it is 0 from the accepting edge until the edge after the rsp_valid pulse.
  - The request fields (addr, size, unsigned, wdata) are latched at acceptance.
  - rsp_valid has no backpressure and lasts exactly one cycle.
- Offset: off = addr[1:0].
- Misalignment rules:
  - Half is misaligned if off[0] = 1.
  - Word is misaligned if off != 0.
  - Size 11 is always an error, independent of the optional feature.
- States: IDLE, RD, WAIT, WR, RESP.
- IDLE, on acceptance:
  - Error request: go to RESP with rsp_err = 1. No memory strobe is ever asserted.
  - Load, or sub-word store: go to RD.
  - Word store: go to WR.
- RD: mem_load = 1 for exactly this cycle; then go to WAIT.
- WAIT: hold until mem_rvalid. On mem_rvalid, capture mem_rdata, then:
  - Load: format the data and go to RESP.
  - Sub-word store: merge and go to WR.
- Load formatting:
  - Byte: rdata[8*off +: 8], extended.
  - Half: rdata[16*off[1] +: 16], extended.
  - Word: rdata unchanged.
  - Sign-extend unless req_unsigned. For word loads, req_unsigned is ignored.
- Store merge:
  - Byte: replace lane off with wdata[7:0].
  - Half: replace lanes off[1]*2 and off[1]*2+1 with wdata[15:0].
- WR: mem_store = 1 with mem_wdata for exactly this cycle; then go to RESP.
  - For a word store, mem_wdata = wdata.
- RESP: rsp_valid = 1 for one cycle; go to IDLE.
- Latency, counted as edges from the accepting edge to the edge after which rsp_valid = 1:
  - Error: 1.
  - Word store: 2.
  - Load: 3.
  - Sub-word store: 4.
  - Each cycle mem_rvalid is late adds 1.
- mem_addr is held stable from the accepting edge until return to IDLE. Addresses above MEM_WORDS*4 wrap modulo the memory size because only IDX_W index bits are used.
- mem_rvalid outside WAIT is ignored.
- Reset mid-operation:
  - On the next edge: go to IDLE and clear all strobes, rsp_valid and latched data.
  - No response is ever issued for the aborted request.
  - A sub-word store aborted before WR leaves memory untouched.

Optional Feature:
- Macro: LSU_MISALIGN_TRAP_EN.
- Defined: misaligned half/word requests produce rsp_err = 1 with 1-edge latency and no memory access.
- Undefined: the misaligned address is aligned down (half: off[0] forced to 0; word: off forced to 00) and the access is performed normally with rsp_err = 0.
- Size 11 is an error in both builds.

Test Plan:
1. Hold reset 2 cycles -> req_ready = 1; rsp_valid, mem_load, mem_store, rsp_err = 0; state IDLE.
2. Word 4 = 0x80A1B2C3; load word at addr 0x10 -> mem_addr = 4; one mem_load pulse; rsp_valid exactly 3 edges after accept; rsp_rdata = 0x80A1B2C3.
3. Same memory, sub-word loads:
   - LB at 0x13 -> 0xFFFFFF80.
   - LBU at 0x13 -> 0x00000080.
   - LH at 0x12 -> 0xFFFF80A1.
   - LHU at 0x10 -> 0x0000B2C3.
4. Sub-word and word stores over 0x80A1B2C3:
   - SB 0x5A at 0x11 -> mem_load then mem_store with mem_wdata = 0x80A15AC3; rsp_valid 4 edges after accept.
   - SW 0x12345678 at 0x10 -> no mem_load; rsp at 2 edges.
5. LH at 0x11:
   - With LSU_MISALIGN_TRAP_EN: rsp_err = 1 at 1 edge, no strobes.
   - Without: mem_addr = 4, rsp_rdata = 0xFFFFB2C3.
   - Size 11 gives rsp_err = 1 in both builds.
6. Assert reset while in WAIT, then drive mem_rvalid -> IDLE with req_ready = 1; no rsp_valid pulse; the following load completes normally.
